banco_registradores: RTL and testbench
======================================

Name: banco_registradores

Overview:
- Parametrised multi-entry register bank. It generalises the single load-enabled register to DEPTH entries of WIDTH bits.
- Two asynchronous read ports and one synchronous write port with byte enables.
- Optional hardwired-zero entry 0.
- Sequential bulk-clear engine that sweeps one entry per cycle under a Busy flag.
- Serves as the CPU general-purpose register file. Sits between the instruction-decode datapath and the ALU operand muxes.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of entries; 2 <= DEPTH <= 2**ADDR_W.
- ADDR_W, 5, address width.
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes; when 0 entry 0 is an ordinary entry.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- RegWrite  input  1  write request.
- WriteAddr  input  ADDR_W  write entry index.
- WriteData  input  WIDTH  write data.
- ByteEn  input  WIDTH/8  per-byte write enable; bit i covers bits [8i+7:8i].
- ReadAddr1  input  ADDR_W  read port 1 index.
- ReadAddr2  input  ADDR_W  read port 2 index.
- ReadData1  output  WIDTH  read port 1 data (combinational).
- ReadData2  output  WIDTH  read port 2 data (combinational).
- Clear  input  1  bulk-clear start request.
- Busy  output  1  high while the clear sweep is in progress.
- ClearDone  output  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset (reset=0 at a rising edge):
  - All DEPTH entries become 0 in that single cycle.
  - Busy=0, ClearDone=0, sweep counter=0. Pending sweep is aborted.
  - Reset overrides every other input.
- Reads:
  - Combinational from the storage array, zero latency.
  - ReadData = 0 when the address is >= DEPTH.
  - ReadData = 0 when the address is 0 and ZERO_REG=1.
  - Both ports may read the same address.
- Write:
  - Occurs at a rising edge when RegWrite=1, Busy=0, Clear=0 and WriteAddr < DEPTH.
  - Only bytes with ByteEn[i]=1 are updated; other bytes hold.
  - RegWrite with ByteEn all-zero is a no-op.
  - Writes to address 0 with ZERO_REG=1 are discarded.
  - Writes to address >= DEPTH are discarded with no side effects.
  - New data is visible on the read ports the cycle after the write edge; same-cycle behaviour is set by the Optional Feature.
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP: at the edge where Clear=1 and Busy=0. Busy becomes 1, counter=0, and no entry is cleared at this edge.
  - In SWEEP, each edge: entry[counter] <= 0, counter <= counter+1.
  - At the edge that clears entry DEPTH-1: return to IDLE, Busy=0, ClearDone=1 for exactly one cycle.
  - Busy is therefore high for exactly DEPTH cycles.
  - Clear while Busy=1 is ignored (no restart).
  - RegWrite during Busy=1 is dropped; the entry is unchanged by the write.
  - Clear and RegWrite in the same cycle with Busy=0: clear starts and the write is dropped.
  - Reads during SWEEP return current contents: entries below counter read 0, others hold old data.
- Counter is ADDR_W+1 bits wide so DEPTH = 2**ADDR_W terminates without wrap ambiguity.

Optional Feature:
- Macro: BANCO_BYPASS_EN.
- Defined: write-to-read forwarding. When a write qualifies this cycle (all write conditions above true) and ReadAddrN == WriteAddr:
  - ReadDataN shows the merged value combinationally in the same cycle.
  - Enabled bytes take WriteData; disabled bytes keep stored data.
  - Zero-entry and out-of-range rules still take priority.
- Not defined: ReadDataN shows the pre-write stored value until the next cycle.

Test Plan:
- Reset: write 0xDEADBEEF to entry 5, then drive reset=0 for one edge -> ReadData1(addr 5)=0x00000000, Busy=0, ClearDone=0.
- Byte enables: entry 3=0x11223344; write 0xAABBCCDD with ByteEn=4'b0101 -> entry 3 reads 0x11BB33DD.
- Zero register: ZERO_REG=1, write 0xFFFFFFFF to entry 0 -> reads 0. Entry 31 written with 0x12345678 -> read 0x12345678 on both ports simultaneously.
- Clear sweep, DEPTH=32:
  - Fill all entries with their index, pulse Clear.
  - Busy is high for exactly 32 cycles.
  - After 10 sweep edges, entry 9 reads 0 and entry 10 reads 10.
  - ClearDone pulses once; all entries read 0 afterwards.
- Conflicts:
  - RegWrite(addr 7, 0x55) during Busy -> entry 7 reads 0 after the sweep.
  - Clear+RegWrite in the same cycle -> write dropped.
  - Clear during Busy -> Busy length unchanged (32).
- Bypass: same-cycle write 0xCAFEF00D to entry 4 with ReadAddr1=4.
  - With BANCO_BYPASS_EN -> ReadData1=0xCAFEF00D that cycle.
  - Without -> old value that cycle, new value next cycle.

Source files
------------

// File: rtl/banco_registradores.sv
// banco_registradores: DEPTH x WIDTH register file, 2 async reads, byte-enabled write, sequential bulk clear.
// Define BANCO_BYPASS_EN to forward a qualifying write to the read ports in the same cycle.
module banco_registradores #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RegWrite,
  input  logic [ADDR_W-1:0]    WriteAddr,
  input  logic [WIDTH-1:0]     WriteData,
  input  logic [WIDTH/8-1:0]   ByteEn,
  input  logic [ADDR_W-1:0]    ReadAddr1,
  input  logic [ADDR_W-1:0]    ReadAddr2,
  output logic [WIDTH-1:0]     ReadData1,
  output logic [WIDTH-1:0]     ReadData2,
  input  logic                 Clear,
  output logic                 Busy,
  output logic                 ClearDone
);
  localparam logic IDLE  = 1'b0;
  localparam logic SWEEP = 1'b1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH-1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic             state;
  logic [ADDR_W:0]  cnt;
  logic             done;
  logic             write_ok;
  assign Busy      = state == SWEEP;
  assign ClearDone = done;
  assign write_ok  = RegWrite && !Busy && !Clear && ({1'b0, WriteAddr} < DEPTH_C)
                     && !(ZERO_REG != 0 && WriteAddr == '0);
`ifdef BANCO_BYPASS_EN
  logic [WIDTH-1:0] wmask;
  always_comb begin
    wmask = '0;
    for (int i = 0; i < WIDTH/8; i++) wmask[8*i +: 8] = {8{ByteEn[i]}};
  end
`endif
  function automatic logic [WIDTH-1:0] rd(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] v;
    v = mem[a];
`ifdef BANCO_BYPASS_EN
    if (write_ok && a == WriteAddr) v = (v & ~wmask) | (WriteData & wmask);
`endif
    return ({1'b0, a} >= DEPTH_C || (ZERO_REG != 0 && a == '0)) ? '0 : v;
  endfunction
  assign ReadData1 = rd(ReadAddr1);
  assign ReadData2 = rd(ReadAddr2);
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= state == SWEEP && cnt == LAST_C;
      if (state == IDLE) begin
        if (Clear) begin
          state <= SWEEP;
          cnt   <= '0;
        end else if (write_ok) begin
          for (int i = 0; i < WIDTH/8; i++)
            if (ByteEn[i]) mem[WriteAddr][8*i +: 8] <= WriteData[8*i +: 8];
        end
      end else begin
        // one entry per edge; the final entry returns the engine to idle
        mem[cnt[ADDR_W-1:0]] <= '0;
        cnt <= cnt + 1'b1;
        if (cnt == LAST_C) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_banco_registradores.sv
// tb_banco_registradores: directed plus random checks of the register bank against an array-based model.
module tb_banco_registradores;
  localparam int W = 32, D = 32, A = 5;
  logic clk = 0, reset = 0, RegWrite = 0, Clear = 0;
  logic [A-1:0] WriteAddr = 0, ReadAddr1 = 0, ReadAddr2 = 0;
  logic [W-1:0] WriteData = 0;
  logic [W/8-1:0] ByteEn = 0;
  logic [W-1:0] ReadData1, ReadData2;
  logic Busy, ClearDone;
  int n_assert = 0, n_fail = 0;
  logic [W-1:0] m [D];
  bit m_busy = 0, m_done = 0;
  int m_pos = 0;
  int busy_n, done_n;

  banco_registradores #(.WIDTH(W), .DEPTH(D), .ADDR_W(A), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .ByteEn(ByteEn), .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .Clear(Clear), .Busy(Busy),
    .ClearDone(ClearDone)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] d,
                                         input logic [W/8-1:0] be);
    logic [W-1:0] r;
    r = old;
    for (int i = 0; i < W/8; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic bit wq();
    return RegWrite && !m_busy && !Clear && int'(WriteAddr) < D && WriteAddr != 0;
  endfunction

  function automatic logic [W-1:0] exp_rd(input logic [A-1:0] a);
    if (int'(a) >= D || a == 0) return '0;
`ifdef BANCO_BYPASS_EN
    if (wq() && a == WriteAddr) return merge(m[a], WriteData, ByteEn);
`endif
    return m[a];
  endfunction

  task automatic upd();
    if (!reset) begin
      foreach (m[i]) m[i] = '0;
      m_busy = 0; m_pos = 0; m_done = 0;
    end else begin
      m_done = m_busy && m_pos == D-1;
      if (m_busy) begin
        m[m_pos] = '0;
        m_pos++;
        if (m_pos == D) m_busy = 0;
      end else if (Clear) begin
        m_busy = 1; m_pos = 0;
      end else if (wq()) m[WriteAddr] = merge(m[WriteAddr], WriteData, ByteEn);
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/rd1"}, ReadData1, exp_rd(ReadAddr1));
    chk({tag, "/rd2"}, ReadData2, exp_rd(ReadAddr2));
    chk({tag, "/busy"}, W'(Busy), W'(m_busy));
    chk({tag, "/done"}, W'(ClearDone), W'(m_done));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    upd();
    #1;
    check_all(tag);
  endtask

  task automatic wr(input logic [A-1:0] a, input logic [W-1:0] d, input logic [W/8-1:0] be);
    RegWrite = 1; WriteAddr = a; WriteData = d; ByteEn = be;
    tick("wr");
    RegWrite = 0;
  endtask

  initial begin
    tick("reset");
    tick("reset");
    reset = 1;
    tick("idle");
    // reset clears stored data
    wr(5, 32'hDEADBEEF, '1);
    ReadAddr1 = 5; #1;
    chk("pre_rst_e5", ReadData1, 32'hDEADBEEF);
    reset = 0;
    tick("rst_pulse");
    reset = 1;
    chk("rst_e5", ReadData1, 32'h0);
    chk("rst_busy", W'(Busy), 0);
    chk("rst_done", W'(ClearDone), 0);
    // byte enables
    wr(3, 32'h11223344, '1);
    wr(3, 32'hAABBCCDD, 4'b0101);
    ReadAddr1 = 3; #1;
    chk("byte_en", ReadData1, 32'h11BB33DD);
    wr(3, 32'hFFFFFFFF, 4'b0000);
    chk("byte_en_none", ReadData1, 32'h11BB33DD);
    // hardwired zero and dual read
    wr(0, 32'hFFFFFFFF, '1);
    ReadAddr1 = 0; #1;
    chk("zero_reg", ReadData1, 32'h0);
    wr(31, 32'h12345678, '1);
    ReadAddr1 = 31; ReadAddr2 = 31; #1;
    chk("dual_rd1", ReadData1, 32'h12345678);
    chk("dual_rd2", ReadData2, 32'h12345678);
    // full sweep with conflicting write and re-clear inside it
    for (int i = 0; i < D; i++) wr(A'(i), W'(i), '1);
    ReadAddr1 = 9; ReadAddr2 = 10;
    Clear = 1;
    tick("clr_start");
    Clear = 0;
    busy_n = int'(Busy); done_n = 0;
    for (int k = 1; k <= 100 && Busy; k++) begin
      RegWrite = (k == 3); WriteAddr = 7; WriteData = 32'h55; ByteEn = '1;
      Clear = (k == 5);
      tick("sweep");
      RegWrite = 0; Clear = 0;
      busy_n += int'(Busy);
      done_n += int'(ClearDone);
      if (k == 10) begin
        chk("sweep_e9", ReadData1, 32'h0);
        chk("sweep_e10", ReadData2, 32'd10);
      end
    end
    chk("busy_len", W'(busy_n), 32);
    chk("done_cnt", W'(done_n), 1);
    tick("post_sweep");
    for (int i = 0; i < D; i++) begin
      ReadAddr1 = A'(i); ReadAddr2 = 7; #1;
      chk("cleared", ReadData1, 32'h0);
      chk("cleared_e7", ReadData2, 32'h0);
    end
    // Clear and RegWrite together: write dropped
    wr(9, 32'h99, '1);
    RegWrite = 1; WriteAddr = 9; WriteData = 32'h1234; ByteEn = '1; Clear = 1;
    ReadAddr1 = 9;
    tick("clr_wr");
    RegWrite = 0; Clear = 0;
    chk("clr_wr_drop", ReadData1, 32'h99);
    for (int k = 0; k < 100 && Busy; k++) tick("sweep2");
    chk("sweep2_end", W'(Busy), 0);
    // same-cycle write/read on entry 4
    wr(4, 32'h11111111, '1);
    ReadAddr1 = 4;
    RegWrite = 1; WriteAddr = 4; WriteData = 32'hCAFEF00D; ByteEn = '1; #1;
`ifdef BANCO_BYPASS_EN
    chk("bypass_same", ReadData1, 32'hCAFEF00D);
`else
    chk("bypass_same", ReadData1, 32'h11111111);
`endif
    tick("bypass");
    RegWrite = 0; #1;
    chk("bypass_next", ReadData1, 32'hCAFEF00D);
    // random traffic
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(63) != 0);
      RegWrite  = $urandom_range(3) != 0;
      Clear     = $urandom_range(49) == 0;
      WriteAddr = A'($urandom);
      WriteData = $urandom;
      ByteEn    = (W/8)'($urandom);
      ReadAddr1 = $urandom_range(3) == 0 ? WriteAddr : A'($urandom);
      ReadAddr2 = A'($urandom);
      #1;
      check_all("rand_pre");
      tick("rand");
    end
    reset = 1; RegWrite = 0; Clear = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
